pipeline_control: RTL

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_detect.sv | 28 ++
 rtl/pipeline_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
//   ctrl_state_e : FSM encoding (RUN=0, MEM_WAIT=1, FAULT=2; 3 unused)
//   STALL_CNT_W  : width of the saturating stall-cycle counter
//   WAIT_CNT_W   : width of the memory-wait counter (covers MEM_TIMEOUT up to 255)
//   hold_t/flush_t : per-stage control bundles
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } ctrl_state_e;

  localparam int STALL_CNT_W = 16;
  localparam int WAIT_CNT_W  = 8;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
  } hold_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } flush_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard detector (purely combinational).
//   rs1, rs2           : source registers of the instruction in ID
//   uses_rs1, uses_rs2 : the matching source is actually read
//   ex_rd              : destination of the instruction in EX
//   ex_mem_read        : instruction in EX is a load
//   load_use           : ID needs a value the EX load has not produced yet
module pipe_hazard_detect #(
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic                      uses_rs1,
  input  logic                      uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  output logic                      load_use
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = uses_rs1 && (rs1 == ex_rd);
  assign rs2_match = uses_rs2 && (rs2 == ex_rd);

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_control.sv
// Pipeline hazard/stall controller.
//   clk, rst            : clock, asynchronous active-low reset
//   id_rs1/2, id_uses_* : ID-stage source operands
//   ex_rd, ex_mem_read  : EX-stage destination and load flag
//   ex_branch_taken     : taken branch/jump resolved in EX
//   mem_req, mem_ready  : MEM-stage access active / completes this cycle
//   err_clr             : leaves the FAULT state
//   *_hold / *_flush    : per-stage-register keep / bubble controls (combinational)
//   fault, state        : memory-timeout flag and current FSM state
//   stall_cycles        : saturating count of cycles with pc_hold=1
module pipeline_control
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      err_clr,
  output logic                      pc_hold,
  output logic                      if_id_hold,
  output logic                      id_ex_hold,
  output logic                      ex_mem_hold,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      mem_wb_flush,
  output logic                      fault,
  output logic [1:0]                state,
  output logic [STALL_CNT_W-1:0]    stall_cycles
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] ONE_CNT     = WAIT_CNT_W'(1);

  ctrl_state_e           cur_state;
  ctrl_state_e           next_state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] next_wait;
  logic [WAIT_CNT_W-1:0] wait_inc;
  logic                  mem_stall;
  logic                  load_use;
  hold_t                 hold;
  flush_t                flush;

  assign mem_stall = mem_req && !mem_ready;
  assign wait_inc  = wait_cnt + ONE_CNT;

  pipe_hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_hazard (
    .rs1         (id_rs1),
    .rs2         (id_rs2),
    .uses_rs1    (id_uses_rs1),
    .uses_rs2    (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state    <= ST_RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      cur_state <= next_state;
      wait_cnt  <= next_wait;
      if (hold.pc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if chain can leave it unassigned and infer a latch.
  always_comb begin
    next_state = cur_state;
    next_wait  = wait_cnt;
    case (cur_state)
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          next_state = ST_RUN;
          next_wait  = '0;
        end else begin
          next_wait = wait_inc;
          if (wait_inc >= TIMEOUT_CNT) next_state = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (err_clr) begin
          next_state = ST_RUN;
          next_wait  = '0;
        end
      end
      default: begin
        // RUN, and the unused encoding which behaves as RUN.
        next_state = ST_RUN;
        next_wait  = '0;
        if (mem_stall) begin
          next_wait  = ONE_CNT;
          // A timeout of one cycle faults straight out of RUN.
          next_state = (ONE_CNT >= TIMEOUT_CNT) ? ST_FAULT : ST_MEM_WAIT;
        end
      end
    endcase
  end

  // Stage controls, highest priority first: fault, memory stall, taken
  // branch, load-use. Each branch drives hold and flush for a register
  // exclusively, so a register is never told to keep and bubble at once.
  always_comb begin
    hold  = '0;
    flush = '0;
    if (cur_state == ST_FAULT) begin
      hold = '1;
    end else if (mem_stall) begin
      hold         = '1;
      flush.mem_wb = 1'b1;
    end else if (ex_branch_taken) begin
      flush.if_id = 1'b1;
      flush.id_ex = 1'b1;
    end else if (load_use) begin
      hold.pc     = 1'b1;
      hold.if_id  = 1'b1;
      flush.id_ex = 1'b1;
    end
  end

  assign pc_hold      = hold.pc;
  assign if_id_hold   = hold.if_id;
  assign id_ex_hold   = hold.id_ex;
  assign ex_mem_hold  = hold.ex_mem;
  assign if_id_flush  = flush.if_id;
  assign id_ex_flush  = flush.id_ex;
  assign ex_mem_flush = flush.ex_mem;
  assign mem_wb_flush = flush.mem_wb;
  assign fault        = (cur_state == ST_FAULT);
  assign state        = cur_state;

endmodule
